// File: rtl/case_1_mul_share_arb_if.sv
// rtl/case_1_mul_share_arb_if.sv - requester, shared-multiplier and response bundle
// Purpose: groups the handshake and data signals of the shared-multiplier arbiter.
// Signals:
//   req_valid/req_ready  per-requester operand handshake (ready is one-hot or zero)
//   req_din0/req_din1    packed operands, requester i at [i*W +: W]
//   mul_din0/mul_din1    registered operands to the shared multiplier
//   mul_dout             combinational product from the shared multiplier
//   rsp_valid/rsp_ready  result handshake
//   rsp_dout/rsp_id      truncated product and index of the issuing requester
// Modports: slave = arbiter side, master = requesters/multiplier/consumer side.
interface case_1_mul_share_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DIN0_WIDTH = 7,
  parameter int DIN1_WIDTH = 6,
  parameter int DOUT_WIDTH = 7
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
  logic [DIN0_WIDTH-1:0]         mul_din0;
  logic [DIN1_WIDTH-1:0]         mul_din1;
  logic [DOUT_WIDTH-1:0]         mul_dout;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [DOUT_WIDTH-1:0]         rsp_dout;
  logic [ID_WIDTH-1:0]           rsp_id;

  modport slave (
    input  req_valid, req_din0, req_din1, mul_dout, rsp_ready,
    output req_ready, mul_din0, mul_din1, rsp_valid, rsp_dout, rsp_id
  );

  modport master (
    output req_valid, req_din0, req_din1, mul_dout, rsp_ready,
    input  req_ready, mul_din0, mul_din1, rsp_valid, rsp_dout, rsp_id
  );
endinterface

// File: rtl/case_1_mul_share_arb.sv
// rtl/case_1_mul_share_arb.sv - round-robin sharing of one signed multiplier
// Purpose: arbitrates NUM_REQ requesters onto one external combinational multiplier,
//   registers the winner's operands, captures the product one cycle later and returns
//   it tagged with the requester index.
// Ports:
//   ap_clk  clock, rising edge
//   ap_rst  synchronous active-high reset
//   bus     case_1_mul_share_arb_if.slave (request, multiplier and response signals)
//   busy    high whenever the sequencer is not idle
module case_1_mul_share_arb #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DIN0_WIDTH = 7,
  parameter int DIN1_WIDTH = 6,
  parameter int DOUT_WIDTH = 7
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  case_1_mul_share_arb_if.slave   bus,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]     id_q;
  logic [DIN0_WIDTH-1:0]   din0_q;
  logic [DIN1_WIDTH-1:0]   din1_q;
  logic [DOUT_WIDTH-1:0]   rsp_dout_q;
  logic [ID_WIDTH-1:0]     rsp_id_q;
  logic                    rsp_valid_q, rsp_valid_d;

  logic                    arb_en;
  logic                    found;
  logic                    grant;
  logic [ID_WIDTH-1:0]     idx;
  logic [ID_WIDTH-1:0]     win;
  logic [NUM_REQ-1:0]      grant_vec;
  logic [DIN0_WIDTH-1:0]   sel_din0;
  logic [DIN1_WIDTH-1:0]   sel_din1;

  // Arbitration: in RESP a new grant is only allowed when the held result is
  // being consumed in the same cycle, so a grant never overwrites a pending result.
  always_comb begin
    arb_en    = !ap_rst && ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));
    found     = 1'b0;
    idx       = '0;
    win       = '0;
    grant_vec = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (arb_en && found) begin
      grant_vec[win] = 1'b1;
    end
  end

  assign grant         = |grant_vec;
  assign bus.req_ready = grant_vec;
  assign rr_ptr_d      = ID_WIDTH'((int'(win) + 1) % NUM_REQ);

  always_comb begin
    sel_din0 = '0;
    sel_din1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_WIDTH'(i)) begin
        sel_din0 = bus.req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
        sel_din1 = bus.req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = MUL;
      MUL:     state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = grant ? MUL : IDLE;
      default: state_d = IDLE;
    endcase
    // A result is presented exactly while the sequencer sits in RESP.
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      din0_q      <= '0;
      din1_q      <= '0;
      rsp_dout_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      if (grant) begin
        din0_q   <= sel_din0;
        din1_q   <= sel_din1;
        id_q     <= win;
        rr_ptr_q <= rr_ptr_d;
      end
      if (state_q == MUL) begin
        rsp_dout_q <= bus.mul_dout;
        rsp_id_q   <= id_q;
      end
    end
  end

  assign bus.mul_din0  = din0_q;
  assign bus.mul_din1  = din1_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dout  = rsp_dout_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_case_1_mul_share_arb.sv
// tb/tb_case_1_mul_share_arb.sv - directed self-checking bench for case_1_mul_share_arb
module tb_case_1_mul_share_arb;

  logic ap_clk = 1'b0;
  logic ap_rst;
  logic busy;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  case_1_mul_share_arb_if #(
    .NUM_REQ(4), .ID_WIDTH(2), .DIN0_WIDTH(7), .DIN1_WIDTH(6), .DOUT_WIDTH(7)
  ) ifc ();

  case_1_mul_share_arb #(
    .NUM_REQ(4), .ID_WIDTH(2), .DIN0_WIDTH(7), .DIN1_WIDTH(6), .DOUT_WIDTH(7)
  ) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (ifc),
    .busy   (busy)
  );

  // Shared multiplier: full signed product, low 7 bits returned.
  logic signed [12:0] prod;
  assign prod         = $signed(ifc.mul_din0) * $signed(ifc.mul_din1);
  assign ifc.mul_dout = prod[6:0];

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [6:0] d0, input logic [5:0] d1);
    ifc.req_din0[i*7 +: 7] = d0;
    ifc.req_din1[i*6 +: 6] = d1;
  endtask

  // Runs one operation from IDLE for a single requester; returns observations only.
  task automatic run_op(input int i, input logic [6:0] d0, input logic [5:0] d1,
                        output logic [6:0] dout, output logic [1:0] id, output int lat);
    set_ops(i, d0, d1);
    ifc.rsp_ready = 1'b0;
    ifc.req_valid = 4'(1 << i);
    tick();
    ifc.req_valid = 4'b0000;
    lat = 1;
    while (!ifc.rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    dout = ifc.rsp_dout;
    id   = ifc.rsp_id;
    ifc.rsp_ready = 1'b1;
    tick();
    ifc.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst        = 1'b1;
    ifc.req_valid = 4'b1111;
    ifc.rsp_ready = 1'b0;
    ifc.req_din0  = '0;
    ifc.req_din1  = '0;
    tick();
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (ifc.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", ifc.rsp_valid); else pass_cnt++;
    total_cnt++; if (ifc.req_ready !== 4'b0000) $display("FAIL reset_req_ready got %b want 0000", ifc.req_ready); else pass_cnt++;
    total_cnt++; if (ifc.mul_din0 !== 7'h00) $display("FAIL reset_mul_din0 got %h want 00", ifc.mul_din0); else pass_cnt++;
    total_cnt++; if (ifc.mul_din1 !== 6'h00) $display("FAIL reset_mul_din1 got %h want 00", ifc.mul_din1); else pass_cnt++;
    total_cnt++; if (ifc.rsp_dout !== 7'h00) $display("FAIL reset_rsp_dout got %h want 00", ifc.rsp_dout); else pass_cnt++;
    total_cnt++; if (ifc.rsp_id !== 2'd0) $display("FAIL reset_rsp_id got %0d want 0", ifc.rsp_id); else pass_cnt++;
    ifc.req_valid = 4'b0000;
    ap_rst        = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    int seen;
    set_ops(2, 7'h11, 6'h03);
    ifc.req_valid = 4'b0100;
    #1;
    total_cnt++; if (ifc.req_ready !== 4'b0100) $display("FAIL midrst_grant got %b want 0100", ifc.req_ready); else pass_cnt++;
    tick();
    ifc.req_valid = 4'b0000;
    total_cnt++; if (busy !== 1'b1) $display("FAIL midrst_busy_mul got %b want 1", busy); else pass_cnt++;
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (ifc.rsp_valid !== 1'b0) $display("FAIL midrst_rsp_valid got %b want 0", ifc.rsp_valid); else pass_cnt++;
    total_cnt++; if (ifc.mul_din0 !== 7'h00) $display("FAIL midrst_mul_din0 got %h want 00", ifc.mul_din0); else pass_cnt++;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ifc.rsp_valid) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL midrst_no_rsp got %0d responses want 0", seen); else pass_cnt++;
    // Pointer back at 0: with everyone valid, requester 0 must win.
    ifc.req_valid = 4'b1111;
    #1;
    total_cnt++; if (ifc.req_ready !== 4'b0001) $display("FAIL midrst_rr_ptr got %b want 0001", ifc.req_ready); else pass_cnt++;
    ifc.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_single_op();
    set_ops(0, 7'h7D, 6'h05);
    ifc.rsp_ready = 1'b0;
    ifc.req_valid = 4'b0001;
    #1;
    total_cnt++; if (ifc.req_ready !== 4'b0001) $display("FAIL single_grant got %b want 0001", ifc.req_ready); else pass_cnt++;
    tick();
    ifc.req_valid = 4'b0000;
    set_ops(0, 7'h00, 6'h00);
    total_cnt++; if (ifc.rsp_valid !== 1'b0) $display("FAIL single_valid_edge1 got %b want 0", ifc.rsp_valid); else pass_cnt++;
    total_cnt++; if (ifc.mul_din0 !== 7'h7D) $display("FAIL single_mul_din0 got %h want 7d", ifc.mul_din0); else pass_cnt++;
    total_cnt++; if (ifc.mul_din1 !== 6'h05) $display("FAIL single_mul_din1 got %h want 05", ifc.mul_din1); else pass_cnt++;
    tick();
    total_cnt++; if (ifc.rsp_valid !== 1'b1) $display("FAIL single_valid_edge2 got %b want 1", ifc.rsp_valid); else pass_cnt++;
    total_cnt++; if (ifc.rsp_dout !== 7'h71) $display("FAIL single_dout got %h want 71", ifc.rsp_dout); else pass_cnt++;
    total_cnt++; if (ifc.rsp_id !== 2'd0) $display("FAIL single_id got %0d want 0", ifc.rsp_id); else pass_cnt++;
    ifc.rsp_ready = 1'b1;
    tick();
    ifc.rsp_ready = 1'b0;
    total_cnt++; if (ifc.rsp_valid !== 1'b0) $display("FAIL single_valid_clear got %b want 0", ifc.rsp_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_idle got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [6:0] dout;
    logic [1:0] id;
    int         lat;
    run_op(1, 7'h3F, 6'h1F, dout, id, lat);
    total_cnt++; if (dout !== 7'h21) $display("FAIL wrap_63x31 got %h want 21", dout); else pass_cnt++;
    total_cnt++; if (id !== 2'd1) $display("FAIL wrap_63x31_id got %0d want 1", id); else pass_cnt++;
    total_cnt++; if (lat !== 2) $display("FAIL wrap_latency got %0d want 2", lat); else pass_cnt++;
    run_op(3, 7'h40, 6'h20, dout, id, lat);
    total_cnt++; if (dout !== 7'h00) $display("FAIL wrap_min_x_min got %h want 00", dout); else pass_cnt++;
    total_cnt++; if (id !== 2'd3) $display("FAIL wrap_min_id got %0d want 3", id); else pass_cnt++;
  endtask

  task automatic test_fairness();
    int nres;
    int last_c;
    for (int i = 0; i < 4; i++) set_ops(i, 7'(i + 1), 6'd2);
    ifc.rsp_ready = 1'b1;
    ifc.req_valid = 4'b1111;
    nres   = 0;
    last_c = 0;
    for (int c = 1; c <= 40 && nres < 8; c++) begin
      tick();
      if (ifc.rsp_valid) begin
        total_cnt++; if (ifc.rsp_id !== 2'(nres % 4)) $display("FAIL fair_id[%0d] got %0d want %0d", nres, ifc.rsp_id, nres % 4); else pass_cnt++;
        total_cnt++; if (ifc.rsp_dout !== 7'(2 * (nres % 4 + 1))) $display("FAIL fair_dout[%0d] got %h want %h", nres, ifc.rsp_dout, 7'(2 * (nres % 4 + 1))); else pass_cnt++;
        if (nres > 0) begin
          total_cnt++; if (c - last_c !== 2) $display("FAIL fair_spacing[%0d] got %0d want 2", nres, c - last_c); else pass_cnt++;
        end
        last_c = c;
        nres++;
        if (nres == 8) ifc.req_valid = 4'b0000;
      end
    end
    ifc.req_valid = 4'b0000;
    total_cnt++; if (nres !== 8) $display("FAIL fair_count got %0d want 8", nres); else pass_cnt++;
    tick();
    ifc.rsp_ready = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL fair_idle got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    set_ops(2, 7'h05, 6'h3E);
    ifc.rsp_ready = 1'b0;
    ifc.req_valid = 4'b0100;
    tick();
    ifc.req_valid = 4'b0000;
    tick();
    set_ops(0, 7'h01, 6'h01);
    set_ops(1, 7'h7E, 6'h07);
    set_ops(3, 7'h02, 6'h02);
    ifc.req_valid = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      #1;
      total_cnt++; if (ifc.rsp_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b want 1", c, ifc.rsp_valid); else pass_cnt++;
      total_cnt++; if (ifc.rsp_dout !== 7'h76) $display("FAIL bp_dout[%0d] got %h want 76", c, ifc.rsp_dout); else pass_cnt++;
      total_cnt++; if (ifc.rsp_id !== 2'd2) $display("FAIL bp_id[%0d] got %0d want 2", c, ifc.rsp_id); else pass_cnt++;
      total_cnt++; if (ifc.req_ready !== 4'b0000) $display("FAIL bp_req_ready[%0d] got %b want 0000", c, ifc.req_ready); else pass_cnt++;
      total_cnt++; if ({ifc.mul_din0, ifc.mul_din1} !== {7'h05, 6'h3E}) $display("FAIL bp_mul_din[%0d] got %h/%h want 05/3e", c, ifc.mul_din0, ifc.mul_din1); else pass_cnt++;
      tick();
    end
    ifc.req_valid = 4'b0010;
    ifc.rsp_ready = 1'b1;
    #1;
    total_cnt++; if (ifc.req_ready !== 4'b0010) $display("FAIL b2b_grant got %b want 0010", ifc.req_ready); else pass_cnt++;
    tick();
    ifc.req_valid = 4'b0000;
    ifc.rsp_ready = 1'b0;
    total_cnt++; if (ifc.rsp_valid !== 1'b0) $display("FAIL b2b_valid_mul got %b want 0", ifc.rsp_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (ifc.mul_din0 !== 7'h7E) $display("FAIL b2b_mul_din0 got %h want 7e", ifc.mul_din0); else pass_cnt++;
    tick();
    total_cnt++; if (ifc.rsp_valid !== 1'b1) $display("FAIL b2b_valid got %b want 1", ifc.rsp_valid); else pass_cnt++;
    total_cnt++; if (ifc.rsp_id !== 2'd1) $display("FAIL b2b_id got %0d want 1", ifc.rsp_id); else pass_cnt++;
    total_cnt++; if (ifc.rsp_dout !== 7'h72) $display("FAIL b2b_dout got %h want 72", ifc.rsp_dout); else pass_cnt++;
    ifc.rsp_ready = 1'b1;
    tick();
    ifc.rsp_ready = 1'b0;
  endtask

  task automatic test_pointer_wrap();
    logic [6:0] dout;
    logic [1:0] id;
    int         lat;
    run_op(2, 7'h03, 6'h03, dout, id, lat);
    total_cnt++; if (id !== 2'd2) $display("FAIL ptr_first_id got %0d want 2", id); else pass_cnt++;
    set_ops(0, 7'h04, 6'h04);
    set_ops(3, 7'h05, 6'h05);
    ifc.req_valid = 4'b1001;
    #1;
    total_cnt++; if (ifc.req_ready !== 4'b1000) $display("FAIL ptr_req3_wins got %b want 1000", ifc.req_ready); else pass_cnt++;
    tick();
    ifc.req_valid = 4'b0001;
    tick();
    total_cnt++; if (ifc.rsp_id !== 2'd3) $display("FAIL ptr_rsp3_id got %0d want 3", ifc.rsp_id); else pass_cnt++;
    total_cnt++; if (ifc.rsp_dout !== 7'h19) $display("FAIL ptr_rsp3_dout got %h want 19", ifc.rsp_dout); else pass_cnt++;
    ifc.rsp_ready = 1'b1;
    #1;
    total_cnt++; if (ifc.req_ready !== 4'b0001) $display("FAIL ptr_req0_wins got %b want 0001", ifc.req_ready); else pass_cnt++;
    tick();
    ifc.req_valid = 4'b0000;
    ifc.rsp_ready = 1'b0;
    tick();
    total_cnt++; if (ifc.rsp_id !== 2'd0) $display("FAIL ptr_rsp0_id got %0d want 0", ifc.rsp_id); else pass_cnt++;
    total_cnt++; if (ifc.rsp_dout !== 7'h10) $display("FAIL ptr_rsp0_dout got %h want 10", ifc.rsp_dout); else pass_cnt++;
    ifc.rsp_ready = 1'b1;
    tick();
    ifc.rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_op();
    test_single_op();
    test_wrap();
    test_fairness();
    test_back_to_back();
    test_pointer_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
